ecc_sed_checker: RTL
====================

Name: ecc_sed_checker

Overview:
- Downstream consumer of the single-error-detect (SED) encoder's 13-bit codeword stream.
- Checks even parity on each received codeword and strips the parity bit to recover the 12-bit data word.
- Buffers results in a small FIFO toward a ready/valid sink.
- Maintains error and overflow statistics for the status block.

Parameters:
- DATA_W, 12, data width; codeword width is DATA_W+1 with parity in the MSB.
- DEPTH, 2, output FIFO depth in entries; must be a power of two and at least 2.
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enc_valid  input  1  codeword present this cycle; no backpressure toward the encoder.
- enc_codeword  input  DATA_W+1  {parity, data}; even parity across all DATA_W+1 bits.
- dec_ready  input  1  sink accepts the FIFO head this cycle.
- clr_stats  input  1  single-cycle pulse; clears err_count, err_sticky and overflow.
- dec_valid  output  1  FIFO non-empty.
- dec_data  output  DATA_W  data field of the FIFO head.
- dec_error  output  1  parity-error flag of the FIFO head.
- err_count  output  CNT_W  number of received codewords with a parity error; saturates.
- err_sticky  output  1  set on any parity error; held until clr_stats.
- overflow  output  1  set when a codeword is dropped because the FIFO is full; held until clr_stats.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO is emptied and all pointers are zeroed.
  - dec_valid=0, dec_data=0, dec_error=0, err_count=0, err_sticky=0, overflow=0.
  - Reset mid-stream discards all buffered entries. The first enc_valid after release is accepted normally.
- Syndrome: syn = XOR of all DATA_W+1 bits of enc_codeword (combinational). syn=1 means parity error.
  - Single-bit errors and any odd number of flipped bits are detected. Even-count flips are not; this is by design.
- Write: on a clock edge with enc_valid=1 and room in the FIFO, the entry {syn, enc_codeword[DATA_W-1:0]} is pushed.
- Room exists when the FIFO is not full, or when it is full and a pop occurs on the same edge (simultaneous push+pop at full is legal).
- Latency: a codeword presented with enc_valid on edge N appears at the head no earlier than after edge N. If the FIFO was empty, dec_valid=1 in the cycle following edge N.
- Pop: on an edge with dec_valid=1 and dec_ready=1, the head entry is removed.
  - dec_ready while the FIFO is empty has no effect.
  - Outputs are driven from the FIFO storage head; the FIFO has no combinational enc_valid to dec_valid path.
- Ordering: strict FIFO. Pointers are log2(DEPTH) bits plus a wrap bit and wrap modulo DEPTH.
- Drop: enc_valid=1 while full with no pop on that edge. The codeword is discarded, overflow is set to 1, and FIFO contents are unchanged.
- Statistics: evaluated on every edge with enc_valid=1, including dropped words.
  - syn=1 increments err_count, saturating at 2^CNT_W-1 with no wrap, and sets err_sticky.
- clr_stats:
  - When clr_stats=1 on an edge, err_count, err_sticky and overflow are first cleared.
  - The same edge's event is then applied: err_count becomes 1 and err_sticky becomes 1 if syn=1; overflow becomes 1 if the word was dropped.
  - clr_stats does not affect FIFO contents.
- dec_data and dec_error are don't-care when dec_valid=0. The bench must check them only while dec_valid=1.

Test Plan:
- Clean passthrough: dec_ready=1; send 13'h0A5C, then 13'h1001 on consecutive cycles. Expect dec_valid for two cycles, dec_data=12'hA5C then 12'h001, dec_error=0 both times, err_count=0.
- Single-bit error: send 13'h1A5C (parity flipped) and 13'h0A58 (data bit 2 flipped). Expect dec_error=1 for each, err_count=2, err_sticky=1.
- Backpressure/overflow with DEPTH=2:
  - dec_ready=0; send 13'h0003, 13'h0005, 13'h0006. Expect the third word dropped, overflow=1, and exactly two entries.
  - Raise dec_ready. Expect 12'h003 then 12'h005, then dec_valid=0.
- Full with simultaneous push+pop: keep the FIFO full, then hold dec_ready=1 and enc_valid=1 on the same edge. Expect no drop, overflow unchanged, occupancy stays 2, and order preserved.
- Counter saturation and clear:
  - Send 260 error codewords. Expect err_count=255.
  - Pulse clr_stats alone. Expect 0/0/0.
  - Pulse clr_stats together with an error codeword. Expect err_count=1 and err_sticky=1.
- Async reset mid-operation: FIFO holds 2 entries and err_count=5; assert rst=0 between edges.
  - Expect all outputs 0 immediately.
  - After release, send 13'h0A5C. Expect it output alone on the next cycle.

Source files
------------

// File: rtl/ecc_sed_checker_if.sv
// Codeword-in / decoded-word-out stream bundle for the SED checker.
// The checker takes the slave view; the producer/sink environment takes the master view.
interface ecc_sed_checker_if #(
    parameter int unsigned DATA_W = 12
);
    logic              enc_valid;
    logic [DATA_W:0]   enc_codeword;
    logic              dec_ready;
    logic              dec_valid;
    logic [DATA_W-1:0] dec_data;
    logic              dec_error;

    modport slave (
        input  enc_valid,
        input  enc_codeword,
        input  dec_ready,
        output dec_valid,
        output dec_data,
        output dec_error
    );

    modport master (
        output enc_valid,
        output enc_codeword,
        output dec_ready,
        input  dec_valid,
        input  dec_data,
        input  dec_error
    );
endinterface

// File: rtl/ecc_sed_checker.sv
// Even-parity checker for the SED codeword stream: strips parity, tags errors,
// buffers results in a small FIFO and keeps error/overflow statistics.
module ecc_sed_checker #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    ecc_sed_checker_if.slave    bus,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    err_count,
    output logic                err_sticky,
    output logic                overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   PtrOne = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ecc_sed_checker: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W:0]    mem_q [DEPTH];
    logic [DATA_W:0]    head;
    logic [PTR_W:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic               err_sticky_q, err_sticky_d;
    logic               overflow_q, overflow_d;
    logic               syn;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    assign syn   = ^bus.enc_codeword;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A pop on the same edge frees the slot, so push at full is allowed then.
    assign pop  = ~empty & bus.dec_ready;
    assign push = bus.enc_valid & (~full | pop);
    assign drop = bus.enc_valid & full & ~pop;

    assign head          = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.dec_valid = ~empty;
    assign bus.dec_data  = empty ? '0 : head[DATA_W-1:0];
    assign bus.dec_error = ~empty & head[DATA_W];

    assign err_count  = err_count_q;
    assign err_sticky = err_sticky_q;
    assign overflow   = overflow_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end
    end

    // Clear first, then fold in this edge's event so a coincident error is not lost.
    always_comb begin
        err_count_d  = clr_stats ? '0   : err_count_q;
        err_sticky_d = clr_stats ? 1'b0 : err_sticky_q;
        overflow_d   = clr_stats ? 1'b0 : overflow_q;
        if (bus.enc_valid && syn) begin
            err_sticky_d = 1'b1;
            if (err_count_d != '1) begin
                err_count_d = err_count_d + CntOne;
            end
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            err_count_q  <= err_count_d;
            err_sticky_q <= err_sticky_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= {syn, bus.enc_codeword[DATA_W-1:0]};
        end
    end

endmodule
